hazard_sched: RTL and testbench

- Pipeline hazard scheduler for the 5-stage core; sits beside the ID stage.
- Tracks destination registers of in-flight instructions in a shadow EX/MEM pipeline.
- Produces registered forwarding selects, load-use stalls, multi-cycle-op stalls and branch-mispredict flush sequencing.
- Drives pc_freeze, do_flush and resolved to the fetch/decode datapath.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_shadow_pipe.sv | 116 +++++++++++
 rtl/hazard_sched.sv | 144 ++++++++++++++
 tb/tb_hazard_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard scheduler: FSM state codes,
// operand-forwarding select codes and the forwarding priority helper.
package hazard_pkg;

  // FSM state encoding (also visible on the debug state port).
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MC_BUSY  = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_EXM = 2'b01;  // EX/MEM pipeline register
  localparam logic [1:0] FWD_MWB = 2'b10;  // MEM/WB pipeline register

  // Forwarding priority for one operand. A load in the EX slot cannot feed
  // EX/MEM (its data is not ready yet), so only a non-load EX hit wins.
  // The younger EX producer beats the older MEM producer.
  function automatic logic [1:0] fwd_select(input logic ex_hit,
                                            input logic ex_load,
                                            input logic mem_hit);
    logic [1:0] sel;
    if (ex_hit && !ex_load) begin
      sel = FWD_EXM;
    end else if (mem_hit) begin
      sel = FWD_MWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EX and MEM slots (valid, destination, write-enable,
// load flag) used to detect RAW hazards against the instruction in ID.
// Produces the load-use hit and the unregistered per-operand forward selects.
module hazard_shadow_pipe #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        state_i,
  input  logic              id_accept_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_we_i,
  input  logic              id_load_i,
  output logic              lu_hit_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o
);
  import hazard_pkg::*;

  logic              ex_v_q,    ex_v_d;
  logic [REG_AW-1:0] ex_rd_q,   ex_rd_d;
  logic              ex_we_q,   ex_we_d;
  logic              ex_load_q, ex_load_d;
  logic              mem_v_q,   mem_v_d;
  logic [REG_AW-1:0] mem_rd_q,  mem_rd_d;
  logic              mem_we_q,  mem_we_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  // A slot matches a source only if it holds a live writer of that register;
  // register 0 is hard-wired and never creates a hazard.
  function automatic logic slot_hit(input logic              v,
                                    input logic              we,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
    return v && we && (rs != {REG_AW{1'b0}}) && (rd == rs);
  endfunction

  // Next-state of the shadow slots, following the real pipeline's movement.
  always_comb begin
    ex_v_d    = ex_v_q;
    ex_rd_d   = ex_rd_q;
    ex_we_d   = ex_we_q;
    ex_load_d = ex_load_q;
    mem_v_d   = mem_v_q;
    mem_rd_d  = mem_rd_q;
    mem_we_d  = mem_we_q;
    case (state_i)
      ST_MC_BUSY: begin
        // Multi-cycle op occupies EX; nothing advances into MEM.
        mem_v_d = 1'b0;
      end
      ST_LU_STALL: begin
        // Keep the load visible in MEM so the waiting consumer forwards from
        // MEM/WB when it is accepted in the following RUN cycle.
        ex_v_d = 1'b0;
      end
      ST_FLUSH: begin
        mem_v_d  = ex_v_q;
        mem_rd_d = ex_rd_q;
        mem_we_d = ex_we_q;
        ex_v_d   = 1'b0;
      end
      default: begin
        // RUN: normal advance; a non-accepted ID slot becomes a bubble.
        mem_v_d  = ex_v_q;
        mem_rd_d = ex_rd_q;
        mem_we_d = ex_we_q;
        if (id_accept_i) begin
          ex_v_d    = 1'b1;
          ex_rd_d   = id_rd_i;
          ex_we_d   = id_we_i;
          ex_load_d = id_load_i;
        end else begin
          ex_v_d = 1'b0;
        end
      end
    endcase
  end

  // Shadow slot registers; reset empties both slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q    <= 1'b0;
      ex_rd_q   <= {REG_AW{1'b0}};
      ex_we_q   <= 1'b0;
      ex_load_q <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_rd_q  <= {REG_AW{1'b0}};
      mem_we_q  <= 1'b0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_rd_q   <= ex_rd_d;
      ex_we_q   <= ex_we_d;
      ex_load_q <= ex_load_d;
      mem_v_q   <= mem_v_d;
      mem_rd_q  <= mem_rd_d;
      mem_we_q  <= mem_we_d;
    end
  end

  // Match comparators, load-use detection and forward selects.
  always_comb begin
    ex_hit_a    = slot_hit(ex_v_q, ex_we_q, ex_rd_q, id_rs1_i);
    ex_hit_b    = slot_hit(ex_v_q, ex_we_q, ex_rd_q, id_rs2_i);
    mem_hit_a   = slot_hit(mem_v_q, mem_we_q, mem_rd_q, id_rs1_i);
    mem_hit_b   = slot_hit(mem_v_q, mem_we_q, mem_rd_q, id_rs2_i);
    lu_hit_o    = id_valid_i && ex_load_q && (ex_hit_a || ex_hit_b);
    fwd_a_sel_o = fwd_select(ex_hit_a, ex_load_q, mem_hit_a);
    fwd_b_sel_o = fwd_select(ex_hit_b, ex_load_q, mem_hit_b);
  end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler for the 5-stage core. Decides each cycle whether
// the ID instruction may enter EX, sequences load-use stalls, multi-cycle-op
// occupancy and mispredict flushes, and registers the EX forwarding selects.
module hazard_sched #(
  parameter int REG_AW    = 5,
  parameter int FLUSH_CYC = 2,
  parameter int MC_LAT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_mc,
  input  logic              ex_br_valid,
  input  logic              ex_br_mispred,
  output logic              id_accept,
  output logic              pc_freeze,
  output logic              do_flush,
  output logic              resolved,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state
);
  import hazard_pkg::*;

  // Counter only ever holds values below the larger of the two lengths.
  localparam int CNT_MAX = (FLUSH_CYC > MC_LAT) ? FLUSH_CYC : MC_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;

  logic       lu_hit;
  logic       mispred;
  logic       in_run;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  hazard_shadow_pipe #(
    .REG_AW (REG_AW)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (state_q),
    .id_accept_i (id_accept),
    .id_valid_i  (id_valid),
    .id_rs1_i    (id_rs1),
    .id_rs2_i    (id_rs2),
    .id_rd_i     (id_rd),
    .id_we_i     (id_we),
    .id_load_i   (id_load),
    .lu_hit_o    (lu_hit),
    .fwd_a_sel_o (fwd_a_sel),
    .fwd_b_sel_o (fwd_b_sel)
  );

  // Handshake and status outputs toward fetch/decode.
  always_comb begin
    mispred   = ex_br_valid && ex_br_mispred;
    in_run    = (state_q == ST_RUN);
    id_accept = id_valid && in_run && !lu_hit && !mispred;
    pc_freeze = !id_accept && (id_valid || !in_run);
    do_flush  = (state_q == ST_FLUSH);
    resolved  = in_run && !lu_hit && !mispred;
  end

  // FSM next state and occupancy counter; mispredict outranks load-use,
  // which outranks starting a multi-cycle op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispred) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
        end else if (lu_hit) begin
          state_d = ST_LU_STALL;
        end else if (id_accept && id_mc) begin
          state_d = ST_MC_BUSY;
          cnt_d   = CNT_W'(MC_LAT - 2);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LU_STALL: begin
        if (mispred) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MC_BUSY, ST_FLUSH: begin
        // Branch resolution is ignored here: EX holds the MC op or a bubble.
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Forward selects are captured only for an instruction entering EX.
  always_comb begin
    if (id_accept) begin
      fwd_a_d = fwd_a_sel;
      fwd_b_d = fwd_b_sel;
    end else begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end
  end

  // State, counter and forward-select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
  assign state = state_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched (REG_AW=5, FLUSH_CYC=2, MC_LAT=4).
// Each scenario drives one ID instruction per cycle from a table, checks the
// control outputs mid-cycle, and pushes the expected forward selects of every
// instruction it expects to be accepted; a monitor pops them one edge later.
module tb_hazard_sched;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mc;
    logic       bv;
    logic       bm;
  } stim_t;

  // Expected control word: {state[1:0], id_accept, pc_freeze, do_flush, resolved}
  localparam logic [5:0] C_IDLE = 6'b00_0001;  // RUN, nothing in ID
  localparam logic [5:0] C_ACC  = 6'b00_1001;  // RUN, instruction accepted
  localparam logic [5:0] C_HOLD = 6'b00_0100;  // RUN, instruction blocked
  localparam logic [5:0] C_LUS  = 6'b01_0100;  // load-use stall
  localparam logic [5:0] C_MCB  = 6'b10_0100;  // multi-cycle busy
  localparam logic [5:0] C_FLS  = 6'b11_0110;  // flushing
  localparam stim_t      NOP    = '0;

  logic       clk, rst_n, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_we, id_load, id_mc, ex_br_valid, ex_br_mispred;
  logic       id_accept, pc_freeze, do_flush, resolved;
  logic [1:0] fwd_a, fwd_b, state;

  int total = 0;
  int bad   = 0;
  logic [3:0] sb_q [$];

  hazard_sched #(.REG_AW(5), .FLUSH_CYC(2), .MC_LAT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_we         (id_we),
    .id_load       (id_load),
    .id_mc         (id_mc),
    .ex_br_valid   (ex_br_valid),
    .ex_br_mispred (ex_br_mispred),
    .id_accept     (id_accept),
    .pc_freeze     (pc_freeze),
    .do_flush      (do_flush),
    .resolved      (resolved),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic mc, input logic bv, input logic bm);
    stim_t s;
    s = {v, rs1, rs2, rd, we, ld, mc, bv, bm};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_valid      = s.v;
    id_rs1        = s.rs1;
    id_rs2        = s.rs2;
    id_rd         = s.rd;
    id_we         = s.we;
    id_load       = s.ld;
    id_mc         = s.mc;
    ex_br_valid   = s.bv;
    ex_br_mispred = s.bm;
  endtask

  // Scoreboard monitor: after each edge, an accepted instruction's expected
  // selects must appear on fwd_a/fwd_b; otherwise the selects must be 00.
  initial begin : monitor
    logic       acc_s;
    logic [3:0] exp_f;
    logic [3:0] got_f;
    forever begin
      @(negedge clk);
      acc_s = id_accept;
      @(posedge clk);
      #1;
      if (rst_n) begin
        got_f = {fwd_a, fwd_b};
        if (acc_s) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_accept got fwd=%b required no accept", got_f);
          end else begin
            exp_f = sb_q.pop_front();
            if (got_f !== exp_f) begin
              bad++;
              $display("FAIL sb_fwd t=%0t got fwd_a/b=%b required=%b", $time, got_f, exp_f);
            end
          end
        end else begin
          total++;
          if (got_f !== 4'b0000) begin
            bad++;
            $display("FAIL fwd_clear t=%0t got fwd_a/b=%b required=0000", $time, got_f);
          end
        end
      end
    end
  end

  task automatic test_reset();
    logic [5:0] obs;
    apply(NOP);
    rst_n = 1'b0;
    #12;
    obs = {state, id_accept, pc_freeze, do_flush, resolved};
    total++;
    if (obs !== C_IDLE) begin
      bad++;
      $display("FAIL reset_ctl got=%b required=%b", obs, C_IDLE);
    end
    total++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_fwd got=%b required=0000", {fwd_a, fwd_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw_chain();
    stim_t      s [6];
    logic [5:0] e [6];
    logic [3:0] f [6];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 3, 1, 0, 0, 0, 0), mk(1, 3, 0, 4, 1, 0, 0, 0, 0),
          mk(1, 0, 3, 6, 1, 0, 0, 0, 0), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_ACC, C_ACC, C_IDLE};
    f = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(f[i]);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL raw_chain cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    stim_t      s [7];
    logic [5:0] e [7];
    logic [3:0] f [7];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 5, 1, 1, 0, 0, 0), mk(1, 0, 5, 8, 1, 0, 0, 0, 0),
          mk(1, 0, 5, 8, 1, 0, 0, 0, 0), mk(1, 0, 5, 8, 1, 0, 0, 0, 0), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_HOLD, C_LUS, C_ACC, C_IDLE};
    f = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(f[i]);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL load_use cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_r0_nowrite();
    stim_t      s [7];
    logic [5:0] e [7];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 0, 1, 1, 0, 0, 0), mk(1, 0, 0, 0, 1, 0, 0, 0, 0),
          mk(1, 0, 0, 7, 0, 1, 0, 0, 0), mk(1, 7, 7, 1, 1, 0, 0, 0, 0), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_ACC, C_ACC, C_ACC, C_IDLE};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(4'b0000);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL r0_nowrite cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mispredict();
    stim_t      s [8];
    logic [5:0] e [8];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 2, 1, 0, 0, 0, 0), mk(1, 0, 0, 3, 1, 0, 0, 1, 1),
          mk(1, 0, 0, 3, 1, 0, 0, 1, 1), mk(1, 0, 0, 3, 1, 0, 0, 0, 0),
          mk(1, 2, 0, 3, 1, 0, 0, 0, 0), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_HOLD, C_FLS, C_FLS, C_ACC, C_IDLE};
    for (int i = 0; i < 8; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(4'b0000);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL mispredict cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      if (i >= 3 && i <= 5) begin
        total++;
        if (dut.u_pipe.ex_v_q !== (i == 3)) begin
          bad++;
          $display("FAIL mispredict_exv cyc%0d got=%b required=%b", i, dut.u_pipe.ex_v_q, (i == 3));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_multicycle();
    stim_t      s [8];
    logic [5:0] e [8];
    logic [3:0] f [8];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 9, 1, 0, 1, 0, 0), mk(1, 9, 0, 10, 1, 0, 0, 0, 0),
          mk(1, 9, 0, 10, 1, 0, 0, 1, 1), mk(1, 9, 0, 10, 1, 0, 0, 0, 0),
          mk(1, 9, 0, 10, 1, 0, 0, 0, 0), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_MCB, C_MCB, C_MCB, C_ACC, C_IDLE};
    f = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(f[i]);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL multicycle cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lu_then_mc();
    stim_t      s [11];
    logic [5:0] e [11];
    logic [3:0] f [11];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 12, 1, 1, 0, 0, 0),
          mk(1, 12, 0, 13, 1, 0, 1, 0, 0), mk(1, 12, 0, 13, 1, 0, 1, 0, 0),
          mk(1, 12, 0, 13, 1, 0, 1, 0, 0),
          mk(1, 0, 13, 14, 1, 0, 0, 0, 0), mk(1, 0, 13, 14, 1, 0, 0, 0, 0),
          mk(1, 0, 13, 14, 1, 0, 0, 0, 0), mk(1, 0, 13, 14, 1, 0, 0, 0, 0), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_HOLD, C_LUS, C_ACC, C_MCB, C_MCB, C_MCB, C_ACC, C_IDLE};
    f = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
          4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 11; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(f[i]);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL lu_then_mc cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mispred_lu_reset();
    stim_t      s [5];
    logic [5:0] e [5];
    logic [5:0] obs;
    s = '{NOP, NOP, mk(1, 0, 0, 11, 1, 1, 0, 0, 0), mk(1, 11, 0, 15, 1, 0, 0, 1, 1), NOP};
    e = '{C_IDLE, C_IDLE, C_ACC, C_HOLD, C_FLS};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      if (e[i][3]) sb_q.push_back(4'b0000);
      @(negedge clk);
      obs = {state, id_accept, pc_freeze, do_flush, resolved};
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL mispred_lu cyc%0d got=%b required=%b", i, obs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    // Still in FLUSH here; reset asynchronously between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    obs = {state, id_accept, pc_freeze, do_flush, resolved};
    total++;
    if (obs !== C_IDLE) begin
      bad++;
      $display("FAIL async_reset_ctl got=%b required=%b", obs, C_IDLE);
    end
    total++;
    if (dut.u_pipe.ex_v_q !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_exv got=%b required=0", dut.u_pipe.ex_v_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    obs = {state, id_accept, pc_freeze, do_flush, resolved};
    total++;
    if (obs !== C_IDLE) begin
      bad++;
      $display("FAIL post_reset_ctl got=%b required=%b", obs, C_IDLE);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_raw_chain();
    test_load_use();
    test_r0_nowrite();
    test_mispredict();
    test_multicycle();
    test_lu_then_mc();
    test_mispred_lu_reset();
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d entries required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
